// File: rtl/dnn_accel_pkg.sv
// Shared types and constants for the DNN accelerator dot-product engine.
package dnn_accel_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_BIAS = 4'd1,
        S_WT_BIAS = 4'd2,
        S_RD_W    = 4'd3,
        S_WT_W    = 4'd4,
        S_RD_X    = 4'd5,
        S_WT_X    = 4'd6,
        S_MAC     = 4'd7,
        S_FINISH  = 4'd8,
        S_WR      = 4'd9
    } state_t;

    localparam logic [2:0] REG_STATUS      = 3'd0;
    localparam logic [2:0] REG_BIAS_ADDR   = 3'd1;
    localparam logic [2:0] REG_WEIGHT_BASE = 3'd2;
    localparam logic [2:0] REG_ACT_BASE    = 3'd3;
    localparam logic [2:0] REG_OUT_ADDR    = 3'd4;
    localparam logic [2:0] REG_LENGTH      = 3'd5;
    localparam logic [2:0] REG_CTRL        = 3'd6;
    localparam logic [2:0] REG_RESULT      = 3'd7;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int CTRL_RELU_BIT   = 0;

endpackage

// File: rtl/dense_mac_engine_fxp_mac.sv
// Fixed-point multiply-accumulate: acc + (w*x >> FRAC_W), wrapping, no saturation.
module fxp_mac
    import dnn_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic signed [DATA_W-1:0] acc_in,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] x_in,
    output logic signed [DATA_W-1:0] acc_out
);

    logic signed [2*DATA_W-1:0] product;

    // Full-width product, then arithmetic shift keeps the Q-format slice (floor rounding).
    always_comb begin
        product = w_in * x_in;
        acc_out = acc_in + DATA_W'(product >>> FRAC_W);
    end

endmodule

// File: rtl/dense_mac_engine.sv
// Dense-layer neuron engine: CSR slave, single-outstanding SDRAM master, one MAC per element.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | waiting for a start write to the status register
// S_RD_BIAS | bias read request held until accepted
// S_WT_BIAS | waiting for bias data, loads accumulator
// S_RD_W    | weight[i] read request held until accepted
// S_WT_W    | waiting for weight data
// S_RD_X    | activation[i] read request held until accepted
// S_WT_X    | waiting for activation data
// S_MAC     | accumulate one product, advance pointers
// S_FINISH  | apply optional ReLU, latch result
// S_WR      | result write held until accepted, then done
module dense_mac_engine
    import dnn_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic [31:0]       slave_readdata,
    output logic [31:0]       master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    input  logic              master_waitrequest,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid
);

    state_t state_q, state_d;

    logic [31:0]              bias_addr_q;
    logic [31:0]              weight_base_q;
    logic [31:0]              act_base_q;
    logic [31:0]              out_addr_q;
    logic [LEN_W-1:0]         len_q;
    logic                     relu_en_q;
    logic signed [DATA_W-1:0] result_q;
    logic                     done_q;

    logic signed [DATA_W-1:0] acc_q;
    logic signed [DATA_W-1:0] w_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] acc_next;
    logic [31:0]              w_ptr_q;
    logic [31:0]              x_ptr_q;
    logic [LEN_W-1:0]         rem_q;

    logic                     busy;
    logic                     start;
    logic                     cfg_wr;
    logic [31:0]              rd_mux;

    assign busy   = (state_q != S_IDLE);
    assign start  = slave_write && (slave_address == REG_STATUS) && !busy;
    assign cfg_wr = slave_write && !busy;

    fxp_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .acc_in  (acc_q),
        .w_in    (w_q),
        .x_in    (x_q),
        .acc_out (acc_next)
    );

    // Configuration registers; frozen while a job runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_addr_q   <= '0;
            weight_base_q <= '0;
            act_base_q    <= '0;
            out_addr_q    <= '0;
            len_q         <= '0;
            relu_en_q     <= 1'b0;
        end else if (cfg_wr) begin
            case (slave_address)
                REG_BIAS_ADDR:   bias_addr_q   <= slave_writedata;
                REG_WEIGHT_BASE: weight_base_q <= slave_writedata;
                REG_ACT_BASE:    act_base_q    <= slave_writedata;
                REG_OUT_ADDR:    out_addr_q    <= slave_writedata;
                REG_LENGTH:      len_q         <= slave_writedata[LEN_W-1:0];
                REG_CTRL:        relu_en_q     <= slave_writedata[CTRL_RELU_BIT];
                default: ;
            endcase
        end
    end

    // CSR read multiplexer.
    always_comb begin
        rd_mux = '0;
        case (slave_address)
            REG_STATUS: begin
                rd_mux[STATUS_BUSY_BIT] = busy;
                rd_mux[STATUS_DONE_BIT] = done_q;
            end
            REG_BIAS_ADDR:   rd_mux = bias_addr_q;
            REG_WEIGHT_BASE: rd_mux = weight_base_q;
            REG_ACT_BASE:    rd_mux = act_base_q;
            REG_OUT_ADDR:    rd_mux = out_addr_q;
            REG_LENGTH:      rd_mux = 32'(len_q);
            REG_CTRL:        rd_mux[CTRL_RELU_BIT] = relu_en_q;
            REG_RESULT:      rd_mux = 32'(result_q);
            default:         rd_mux = '0;
        endcase
    end

    // Registered read data; status sampled here is the pre-start value on a same-cycle start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slave_readdata <= '0;
        end else if (slave_read) begin
            slave_readdata <= rd_mux;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and master bus outputs, all decoded from the current state.
    always_comb begin
        state_d          = state_q;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RD_BIAS;
            end
            S_RD_BIAS: begin
                master_read    = 1'b1;
                master_address = bias_addr_q;
                if (!master_waitrequest) state_d = S_WT_BIAS;
            end
            S_WT_BIAS: begin
                if (master_readdatavalid) state_d = (len_q == '0) ? S_FINISH : S_RD_W;
            end
            S_RD_W: begin
                master_read    = 1'b1;
                master_address = w_ptr_q;
                if (!master_waitrequest) state_d = S_WT_W;
            end
            S_WT_W: begin
                if (master_readdatavalid) state_d = S_RD_X;
            end
            S_RD_X: begin
                master_read    = 1'b1;
                master_address = x_ptr_q;
                if (!master_waitrequest) state_d = S_WT_X;
            end
            S_WT_X: begin
                if (master_readdatavalid) state_d = S_MAC;
            end
            S_MAC: begin
                state_d = (rem_q == LEN_W'(1)) ? S_FINISH : S_RD_W;
            end
            S_FINISH: begin
                state_d = S_WR;
            end
            S_WR: begin
                master_write     = 1'b1;
                master_address   = out_addr_q;
                master_writedata = result_q;
                if (!master_waitrequest) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, accumulate, element down-counter and sticky done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            w_q      <= '0;
            x_q      <= '0;
            w_ptr_q  <= '0;
            x_ptr_q  <= '0;
            rem_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        w_ptr_q <= weight_base_q;
                        x_ptr_q <= act_base_q;
                        rem_q   <= len_q;
                        done_q  <= 1'b0;
                    end
                end
                S_WT_BIAS: if (master_readdatavalid) acc_q <= master_readdata;
                S_WT_W:    if (master_readdatavalid) w_q   <= master_readdata;
                S_WT_X:    if (master_readdatavalid) x_q   <= master_readdata;
                S_MAC: begin
                    acc_q   <= acc_next;
                    w_ptr_q <= w_ptr_q + 32'd4;
                    x_ptr_q <= x_ptr_q + 32'd4;
                    rem_q   <= rem_q - LEN_W'(1);
                end
                S_FINISH: begin
                    result_q <= (relu_en_q && acc_q[DATA_W-1]) ? '0 : acc_q;
                end
                S_WR: begin
                    if (!master_waitrequest) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
